dtw_query_sched: RTL and testbench
==================================

DTW_QUERY_SCHED -- requirements
Module: dtw_query_sched

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of DTW cores served (2..8).
REQ-002 SHALL have parameter SQG_SIZE, default 250: squiggle samples per query packet.
REQ-003 SHALL have parameter axi_dwidth, default 32: word width of all FIFO data ports.
REQ-004 SHALL have one clock, clk, and reset rst, synchronous and active-high; clk input 1, rst input 1.
REQ-005 SHALL have these ports:
  - enable  input  1  permit starting new dispatches.
  - src_fifo_rden  output  1  pop upstream query FIFO.
  - src_fifo_empty  input  1  upstream FIFO empty.
  - src_fifo_data  input  axi_dwidth  upstream head word; first-word-fall-through, valid while !empty.
  - core_fifo_wren  output  N_CORES  one-hot write to the selected core input FIFO.
  - core_fifo_full  input  N_CORES  core input FIFO full flags.
  - core_fifo_data  output  axi_dwidth  shared core input data.
  - core_busy  input  N_CORES  core busy flags.
  - res_fifo_rden  output  N_CORES  one-hot pop of a core result FIFO.
  - res_fifo_empty  input  N_CORES  result FIFO empty flags.
  - res_fifo_data  input  N_CORES*axi_dwidth  result head words; core i occupies bits [i*axi_dwidth +: axi_dwidth]; FWFT.
  - sink_fifo_wren  output  1  write merged result.
  - sink_fifo_full  input  1  sink full.
  - sink_fifo_data  output  axi_dwidth  merged result word.
  - dispatched_cnt  output  32  queries dispatched.
  - collected_cnt  output  32  results collected.
  - sched_idle  output  1  no query in flight.

Function
REQ-006 A query packet SHALL be SQG_SIZE+1 words: word 0 = qid, then SQG_SIZE samples. A result SHALL be 3 words: qid, position, minval.
REQ-007 The block SHALL keep an assigned[N_CORES] register. A bit is set at dispatch start and cleared when that core's third result word is written to sink.
REQ-008 The dispatch FSM SHALL have states D_IDLE, D_XFER.
  - D_IDLE to D_XFER when enable=1, src_fifo_empty=0 and at least one core has assigned=0 and core_busy=0.
  - sel_d SHALL be the first such core searched cyclically from pointer rr_d.
  - assigned[sel_d] SHALL be set on the transition.
REQ-009 In D_XFER, a word SHALL transfer in every cycle with src_fifo_empty=0 and core_fifo_full[sel_d]=0.
  - src_fifo_rden=1, core_fifo_wren[sel_d]=1, core_fifo_data=src_fifo_data, all combinational in that cycle.
  - Otherwise the transfer SHALL stall with rden=0 and wren=0.
REQ-010 A word counter (0..SQG_SIZE) SHALL advance per transferred word. On the transfer at count SQG_SIZE:
  - dispatched_cnt increments;
  - rr_d becomes (sel_d+1) mod N_CORES;
  - the FSM returns to D_IDLE.
REQ-011 Deasserting enable mid-packet SHALL NOT abort the packet; it only blocks the next D_IDLE exit.
REQ-012 The collect FSM SHALL have states C_IDLE, C_XFER.
  - C_IDLE to C_XFER when some core has assigned=1 and res_fifo_empty=0.
  - sel_c SHALL be chosen cyclically from pointer rr_c.
REQ-013 In C_XFER, a word SHALL transfer in every cycle with res_fifo_empty[sel_c]=0 and sink_fifo_full=0.
  - res_fifo_rden[sel_c]=1, sink_fifo_wren=1, sink_fifo_data=res_fifo_data slice of sel_c, all combinational.
  - Otherwise the transfer SHALL stall.
  - The 3 words of one result SHALL never interleave with another core's words.
REQ-014 On the third result word:
  - assigned[sel_c] clears;
  - collected_cnt increments;
  - rr_c becomes (sel_c+1) mod N_CORES;
  - the FSM returns to C_IDLE.
REQ-015 The two FSMs SHALL run concurrently. Set and clear of assigned bits for different cores in the same cycle SHALL both take effect. The same core cannot be set and cleared together.
REQ-016 Outputs outside active transfers SHALL be 0: core_fifo_wren, res_fifo_rden, src_fifo_rden, sink_fifo_wren.
REQ-017 sched_idle SHALL be 1 iff both FSMs are idle and assigned==0.
REQ-018 Counters SHALL wrap modulo 2^32.

Reset
REQ-019 With rst=1 at a clock edge, the block SHALL return to its reset state, including mid-packet:
  - both FSMs go to idle;
  - assigned=0, rr_d=rr_c=0, word counters=0;
  - dispatched_cnt=collected_cnt=0;
  - sched_idle=1 from the next cycle.
REQ-020 All strobes SHALL be 0 while rst=1.

Verification
REQ-021 Single query: N_CORES=4, all cores idle, 251 words in the source -> core 0 receives 251 writes in consecutive cycles; dispatched_cnt=1; core 0 result {7, 0x120, 0x55} appears at sink in 3 consecutive cycles; collected_cnt=1; sched_idle=1.
REQ-022 Round robin: 5 packets queued, cores never return results -> packets go to cores 0,1,2,3; the fifth is held until core 2's result is collected, then goes to core 2.
REQ-023 Backpressure: core_fifo_full[0] high for cycles 10-14 of a transfer -> no rden/wren in those cycles, no word lost; src_fifo_empty pulses handled likewise.
REQ-024 Atomic merge: cores 1 and 3 results ready in the same cycle, sink_fifo_full toggling -> sink receives all 3 words of core 1, then all 3 of core 3.
REQ-025 Reset mid-packet at word 100 -> all strobes 0 and counters 0 next cycle; a new packet afterwards dispatches to core 0.
REQ-026 enable dropped at word 50 -> the packet completes with 251 words total; no new dispatch until enable=1.

Source files
------------

// File: rtl/dtw_query_sched.sv
// Query scheduler for a bank of DTW cores.
// Dispatch side: moves (SQG_SIZE+1)-word query packets from an upstream
// FWFT FIFO into the input FIFO of a free core, picking cores round-robin.
// Collect side: moves 3-word results from core result FIFOs into a sink
// FIFO, one whole result at a time, also round-robin.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            permit starting new dispatches
//   src_fifo_*        upstream query FIFO (rden out, empty/data in)
//   core_fifo_*       per-core input FIFOs (one-hot wren, shared data out)
//   core_busy         per-core busy flags
//   res_fifo_*        per-core result FIFOs (one-hot rden, packed data in)
//   sink_fifo_*       merged result FIFO (wren/data out, full in)
//   dispatched_cnt    completed dispatches, wraps at 2^32
//   collected_cnt     completed collections, wraps at 2^32
//   sched_idle        nothing assigned and both engines idle
module dtw_query_sched #(
   parameter int unsigned N_CORES    = 4,
   parameter int unsigned SQG_SIZE   = 250,
   parameter int unsigned axi_dwidth = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   output logic                          src_fifo_rden,
   input  logic                          src_fifo_empty,
   input  logic [axi_dwidth-1:0]         src_fifo_data,
   output logic [N_CORES-1:0]            core_fifo_wren,
   input  logic [N_CORES-1:0]            core_fifo_full,
   output logic [axi_dwidth-1:0]         core_fifo_data,
   input  logic [N_CORES-1:0]            core_busy,
   output logic [N_CORES-1:0]            res_fifo_rden,
   input  logic [N_CORES-1:0]            res_fifo_empty,
   input  logic [N_CORES*axi_dwidth-1:0] res_fifo_data,
   output logic                          sink_fifo_wren,
   input  logic                          sink_fifo_full,
   output logic [axi_dwidth-1:0]         sink_fifo_data,
   output logic [31:0]                   dispatched_cnt,
   output logic [31:0]                   collected_cnt,
   output logic                          sched_idle
);

   localparam int unsigned IW = $clog2(N_CORES);
   localparam int unsigned CW = $clog2(SQG_SIZE + 1);
   localparam int unsigned DW = axi_dwidth;
   localparam logic [IW-1:0] LAST_CORE = IW'(N_CORES - 1);
   localparam logic [CW-1:0] LAST_WORD = CW'(SQG_SIZE);

   typedef enum logic {D_IDLE, D_XFER} d_state_t;
   typedef enum logic {C_IDLE, C_XFER} c_state_t;

   d_state_t d_state, d_next;
   c_state_t c_state, c_next;

   logic [N_CORES-1:0] assigned, set_mask, clr_mask;
   logic [IW-1:0]      rr_d, rr_c, sel_d, sel_c, pick_d, pick_c;
   logic               found_d, found_c;
   logic               d_start, d_xfer, d_last;
   logic               c_start, c_xfer, c_last;
   logic [CW-1:0]      d_cnt;
   logic [1:0]         c_cnt;

   // First requesting index at or after ptr, wrapping; MSB flags a hit.
   function automatic logic [IW:0] rr_pick(input logic [N_CORES-1:0] req,
                                           input logic [IW-1:0]      ptr);
      logic [IW:0]   res;
      logic [IW-1:0] idx;
      res = '0;
      for (int unsigned k = 0; k < N_CORES; k++) begin
         idx = IW'((32'(ptr) + k) % N_CORES);
         if (!res[IW] && req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign {found_d, pick_d} = rr_pick(~assigned & ~core_busy, rr_d);
   assign {found_c, pick_c} = rr_pick(assigned & ~res_fifo_empty, rr_c);

   assign core_fifo_data = src_fifo_data;
   assign sink_fifo_data = res_fifo_data[32'(sel_c) * DW +: DW];
   assign sched_idle     = (d_state == D_IDLE) && (c_state == C_IDLE) && (assigned == '0);

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         d_state <= D_IDLE;
         c_state <= C_IDLE;
      end else begin
         d_state <= d_next;
         c_state <= c_next;
      end
   end

   // Dispatch engine: next state and pass-through strobes
   always_comb begin
      d_next         = d_state;
      d_start        = 1'b0;
      d_xfer         = 1'b0;
      d_last         = 1'b0;
      src_fifo_rden  = 1'b0;
      core_fifo_wren = '0;
      set_mask       = '0;
      case (d_state)
         D_IDLE: begin
            if (enable && !src_fifo_empty && found_d) begin
               d_next           = D_XFER;
               d_start          = 1'b1;
               set_mask[pick_d] = 1'b1;
            end
         end
         D_XFER: begin
            if (!src_fifo_empty && !core_fifo_full[sel_d]) begin
               d_xfer                = 1'b1;
               src_fifo_rden         = 1'b1;
               core_fifo_wren[sel_d] = 1'b1;
               if (d_cnt == LAST_WORD) begin
                  d_last = 1'b1;
                  d_next = D_IDLE;
               end
            end
         end
         default: d_next = D_IDLE;
      endcase
      if (rst) begin
         src_fifo_rden  = 1'b0;
         core_fifo_wren = '0;
      end
   end

   // Collect engine: next state and pass-through strobes
   always_comb begin
      c_next         = c_state;
      c_start        = 1'b0;
      c_xfer         = 1'b0;
      c_last         = 1'b0;
      res_fifo_rden  = '0;
      sink_fifo_wren = 1'b0;
      clr_mask       = '0;
      case (c_state)
         C_IDLE: begin
            if (found_c) begin
               c_next  = C_XFER;
               c_start = 1'b1;
            end
         end
         C_XFER: begin
            if (!res_fifo_empty[sel_c] && !sink_fifo_full) begin
               c_xfer               = 1'b1;
               res_fifo_rden[sel_c] = 1'b1;
               sink_fifo_wren       = 1'b1;
               if (c_cnt == 2'd2) begin
                  c_last          = 1'b1;
                  clr_mask[sel_c] = 1'b1;
                  c_next          = C_IDLE;
               end
            end
         end
         default: c_next = C_IDLE;
      endcase
      if (rst) begin
         res_fifo_rden  = '0;
         sink_fifo_wren = 1'b0;
      end
   end

   // Core ownership, selections, word counters, round-robin pointers, totals.
   // A core cannot be set and cleared together: set needs assigned=0, clear needs 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         assigned       <= '0;
         rr_d           <= '0;
         rr_c           <= '0;
         sel_d          <= '0;
         sel_c          <= '0;
         d_cnt          <= '0;
         c_cnt          <= '0;
         dispatched_cnt <= '0;
         collected_cnt  <= '0;
      end else begin
         assigned <= (assigned & ~clr_mask) | set_mask;

         if (d_start) begin
            sel_d <= pick_d;
            d_cnt <= '0;
         end else if (d_xfer) begin
            d_cnt <= d_last ? '0 : d_cnt + CW'(1);
         end
         if (d_last) begin
            dispatched_cnt <= dispatched_cnt + 32'd1;
            rr_d           <= (sel_d == LAST_CORE) ? '0 : sel_d + IW'(1);
         end

         if (c_start) begin
            sel_c <= pick_c;
            c_cnt <= '0;
         end else if (c_xfer) begin
            c_cnt <= c_last ? '0 : c_cnt + 2'd1;
         end
         if (c_last) begin
            collected_cnt <= collected_cnt + 32'd1;
            rr_c          <= (sel_c == LAST_CORE) ? '0 : sel_c + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dtw_query_sched.sv
// Bench for dtw_query_sched: FWFT FIFO models around the scheduler, a
// transaction-level scoreboard (expected core per packet, expected sink word
// stream, packet/result totals) checked every cycle, plus directed scenarios
// with hand-computed literal expectations.
module tb_dtw_query_sched;

   localparam int unsigned NC  = 4;
   localparam int unsigned SQG = 250;
   localparam int unsigned DW  = 32;
   localparam int unsigned PKT = SQG + 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable;
   logic                src_fifo_rden;
   logic                src_fifo_empty;
   logic [DW-1:0]       src_fifo_data;
   logic [NC-1:0]       core_fifo_wren;
   logic [NC-1:0]       core_fifo_full;
   logic [DW-1:0]       core_fifo_data;
   logic [NC-1:0]       core_busy;
   logic [NC-1:0]       res_fifo_rden;
   logic [NC-1:0]       res_fifo_empty;
   logic [NC*DW-1:0]    res_fifo_data;
   logic                sink_fifo_wren;
   logic                sink_fifo_full;
   logic [DW-1:0]       sink_fifo_data;
   logic [31:0]         dispatched_cnt;
   logic [31:0]         collected_cnt;
   logic                sched_idle;

   dtw_query_sched #(.N_CORES(NC), .SQG_SIZE(SQG), .axi_dwidth(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .src_fifo_rden  (src_fifo_rden),
      .src_fifo_empty (src_fifo_empty),
      .src_fifo_data  (src_fifo_data),
      .core_fifo_wren (core_fifo_wren),
      .core_fifo_full (core_fifo_full),
      .core_fifo_data (core_fifo_data),
      .core_busy      (core_busy),
      .res_fifo_rden  (res_fifo_rden),
      .res_fifo_empty (res_fifo_empty),
      .res_fifo_data  (res_fifo_data),
      .sink_fifo_wren (sink_fifo_wren),
      .sink_fifo_full (sink_fifo_full),
      .sink_fifo_data (sink_fifo_data),
      .dispatched_cnt (dispatched_cnt),
      .collected_cnt  (collected_cnt),
      .sched_idle     (sched_idle)
   );

   always #5 clk = ~clk;

   // Environment state
   logic [DW-1:0] src_q[$];
   logic [DW-1:0] res_words[NC][3];
   int            res_left[NC];
   logic          src_gap;
   logic [NC-1:0] full_force;
   logic          sink_ff;

   // Scoreboard
   int            exp_core[$];
   logic [DW-1:0] exp_sink[$];
   int            core_rd, sink_rd;
   int            d_words, c_words, cur_d_core, cur_c_core;
   int            m_disp, m_coll;
   int            cyc, pkt_first, pkt_span, res_first, res_span;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_inputs();
      src_fifo_empty = (src_q.size() == 0) || src_gap;
      src_fifo_data  = (src_q.size() > 0) ? src_q[0] : '0;
      core_fifo_full = full_force;
      sink_fifo_full = sink_ff;
      for (int i = 0; i < NC; i++) begin
         res_fifo_empty[i] = (res_left[i] == 0);
         res_fifo_data[i*DW +: DW] = (res_left[i] > 0) ? res_words[i][3 - res_left[i]] : '0;
      end
   endtask

   // Per-cycle scoreboard comparison, sampled mid-cycle
   task automatic compare_cycle();
      int            ci;
      logic [DW-1:0] e;
      if (rst) begin
         chk("rst_strobes", {src_fifo_rden, core_fifo_wren, res_fifo_rden, sink_fifo_wren}, '0);
         m_disp = 0; m_coll = 0; d_words = 0; c_words = 0; core_rd = 0; sink_rd = 0;
         return;
      end
      chk("dispatched_cnt", dispatched_cnt, 64'(m_disp));
      chk("collected_cnt", collected_cnt, 64'(m_coll));
      chk("rden_vs_wren", src_fifo_rden, |core_fifo_wren);
      chk("wren_onehot", $countones(core_fifo_wren) <= 1, 1);
      chk("sink_vs_rrden", sink_fifo_wren, |res_fifo_rden);
      chk("rrden_onehot", $countones(res_fifo_rden) <= 1, 1);

      if (|core_fifo_wren) begin
         ci = 0;
         for (int i = 0; i < NC; i++) if (core_fifo_wren[i]) ci = i;
         e = 'x;
         if (src_q.size() > 0) e = src_q[0];
         chk("src_avail", src_fifo_empty, 0);
         chk("core_not_full", core_fifo_full[ci], 0);
         chk("core_data", core_fifo_data, e);
         if (d_words == 0) begin
            chk("dispatch_core", ci, (core_rd < exp_core.size()) ? exp_core[core_rd] : -1);
            cur_d_core = ci;
            pkt_first  = cyc;
         end else begin
            chk("pkt_same_core", ci, cur_d_core);
         end
         d_words++;
         if (d_words == PKT) begin
            d_words  = 0;
            m_disp++;
            core_rd++;
            pkt_span = cyc - pkt_first;
         end
      end

      if (sink_fifo_wren) begin
         ci = 0;
         for (int i = 0; i < NC; i++) if (res_fifo_rden[i]) ci = i;
         e = 'x;
         if (sink_rd < exp_sink.size()) e = exp_sink[sink_rd];
         chk("res_avail", res_left[ci] != 0, 1);
         chk("sink_not_full", sink_fifo_full, 0);
         chk("sink_data", sink_fifo_data, e);
         if (c_words == 0) begin
            cur_c_core = ci;
            res_first  = cyc;
         end else begin
            chk("merge_atomic", ci, cur_c_core);
         end
         c_words++;
         sink_rd++;
         if (c_words == 3) begin
            c_words  = 0;
            m_coll++;
            res_span = cyc - res_first;
         end
      end
   endtask

   // One clock: compare at negedge, FIFO pops applied just after posedge
   task automatic tick();
      logic          pop_s;
      logic [NC-1:0] pop_r;
      drive_inputs();
      @(negedge clk);
      cyc++;
      compare_cycle();
      pop_s = src_fifo_rden;
      pop_r = res_fifo_rden;
      @(posedge clk);
      #1;
      if (pop_s && src_q.size() > 0) void'(src_q.pop_front());
      for (int i = 0; i < NC; i++) if (pop_r[i] && res_left[i] > 0) res_left[i]--;
      drive_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      src_q.delete();
      exp_core.delete();
      exp_sink.delete();
      for (int i = 0; i < NC; i++) res_left[i] = 0;
      src_gap = 1'b0; full_force = '0; sink_ff = 1'b0; core_busy = '0; enable = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      drive_inputs();
   endtask

   task automatic push_pkt(input logic [DW-1:0] qid, input logic [DW-1:0] base);
      src_q.push_back(qid);
      for (int s = 1; s <= SQG; s++) src_q.push_back(base + DW'(s));
   endtask

   task automatic set_res(input int c, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2);
      res_words[c][0] = w0; res_words[c][1] = w1; res_words[c][2] = w2;
      res_left[c] = 3;
      exp_sink.push_back(w0); exp_sink.push_back(w1); exp_sink.push_back(w2);
   endtask

   task automatic wait_disp(input int n, input int budget);
      int k = 0;
      while (m_disp < n && k < budget) begin tick(); k++; end
      chk("wait_disp", m_disp, n);
   endtask

   task automatic wait_coll(input int n, input int budget);
      int k = 0;
      while (m_coll < n && k < budget) begin tick(); k++; end
      chk("wait_coll", m_coll, n);
   endtask

   task automatic wait_words(input int n, input int budget);
      int k = 0;
      while (d_words < n && k < budget) begin tick(); k++; end
      chk("wait_words", d_words, n);
   endtask

   initial begin
      int k;
      cyc = 0; pkt_span = -1; res_span = -1;
      core_rd = 0; sink_rd = 0; d_words = 0; c_words = 0; m_disp = 0; m_coll = 0;
      cur_d_core = 0; cur_c_core = 0; pkt_first = 0; res_first = 0;
      do_reset();
      chk("reset_disp", dispatched_cnt, 0);
      chk("reset_coll", collected_cnt, 0);
      chk("reset_idle", sched_idle, 1);

      // Single query to core 0, result {7, 0x120, 0x55}
      push_pkt(32'd7, 32'h1000);
      exp_core.push_back(0);
      wait_disp(1, 400);
      chk("t1_span", pkt_span, 250);
      chk("t1_disp", dispatched_cnt, 1);
      chk("t1_busy", sched_idle, 0);
      set_res(0, 32'd7, 32'h120, 32'h55);
      wait_coll(1, 50);
      chk("t1_rspan", res_span, 2);
      chk("t1_coll", collected_cnt, 1);
      chk("t1_idle", sched_idle, 1);

      // Round robin, fifth packet held until core 2 frees up
      do_reset();
      for (int p = 1; p <= 5; p++) push_pkt(DW'(p), DW'(p) << 16);
      for (int c = 0; c < 4; c++) exp_core.push_back(c);
      wait_disp(4, 1300);
      chk("t2_disp4", dispatched_cnt, 4);
      repeat (30) tick();
      chk("t2_held", dispatched_cnt, 4);
      chk("t2_src_left", src_q.size(), 251);
      exp_core.push_back(2);
      set_res(2, 32'd3, 32'h300, 32'h30);
      wait_disp(5, 400);
      chk("t2_coll", collected_cnt, 1);
      chk("t2_disp5", dispatched_cnt, 5);

      // Backpressure: core full for 5 cycles, source empty for 4 cycles
      do_reset();
      push_pkt(32'd9, 32'h2000);
      exp_core.push_back(0);
      wait_words(10, 50);
      full_force[0] = 1'b1;
      repeat (5) tick();
      chk("t3_stall_full", d_words, 10);
      full_force[0] = 1'b0;
      wait_words(100, 200);
      src_gap = 1'b1;
      repeat (4) tick();
      chk("t3_stall_empty", d_words, 100);
      src_gap = 1'b0;
      wait_disp(1, 400);
      chk("t3_disp", dispatched_cnt, 1);
      chk("t3_span", pkt_span, 259);

      // Atomic merge of cores 1 and 3 with a toggling sink
      do_reset();
      for (int p = 0; p < 4; p++) push_pkt(DW'(p + 16), DW'(p) << 20);
      for (int c = 0; c < 4; c++) exp_core.push_back(c);
      wait_disp(4, 1300);
      set_res(1, 32'h11, 32'h111, 32'h1111);
      set_res(3, 32'h33, 32'h333, 32'h3333);
      k = 0;
      while (m_coll < 2 && k < 100) begin sink_ff = ~sink_ff; tick(); k++; end
      sink_ff = 1'b0;
      chk("t4_coll", collected_cnt, 2);
      chk("t4_sink_words", sink_rd, 6);
      chk("t4_not_idle", sched_idle, 0);

      // Reset mid-packet at word 100
      do_reset();
      push_pkt(32'd5, 32'h5000);
      exp_core.push_back(0);
      wait_words(100, 200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      src_q.delete();
      exp_core.delete();
      drive_inputs();
      chk("t5_disp", dispatched_cnt, 0);
      chk("t5_idle", sched_idle, 1);
      push_pkt(32'd6, 32'h6000);
      exp_core.push_back(0);
      wait_disp(1, 400);
      chk("t5_span", pkt_span, 250);
      chk("t5_disp1", dispatched_cnt, 1);

      // Enable dropped at word 50; next dispatch skips busy core 1
      do_reset();
      push_pkt(32'd8, 32'h8000);
      push_pkt(32'd9, 32'h9000);
      exp_core.push_back(0);
      wait_words(50, 100);
      enable = 1'b0;
      wait_disp(1, 400);
      chk("t6_span", pkt_span, 250);
      repeat (20) tick();
      chk("t6_held", dispatched_cnt, 1);
      chk("t6_src_left", src_q.size(), 251);
      core_busy = 4'b0010;
      enable = 1'b1;
      exp_core.push_back(2);
      wait_disp(2, 400);
      chk("t6_disp2", dispatched_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
